tlul_err_resp_q: RTL and testbench

Parametrised TL-UL error responder with an outstanding-request queue. It terminates A-channel requests that decode to no valid device and returns error D-channel responses in order. Up to `Depth` requests can be pending, so the host sees full throughput while `d_ready` is held. An optional error log records the response count and the first offending address. It sits on the error port of `tlul_socket_1n` and any other crossbar leaf that needs a default slave.

---
 rtl/tlul_pkg.sv | 47 ++++
 rtl/tlul_err_resp_q.sv | 123 ++++++++++++
 tb/tb_tlul_err_resp_q.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by the error responder and its bench.

package tlul_pkg;

    parameter int TL_AW  = 32;
    parameter int TL_DW  = 32;
    parameter int TL_AIW = 8;
    parameter int TL_DIW = 1;
    parameter int TL_DBW = TL_DW / 8;
    parameter int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_err_resp_q.sv
// TL-UL default-slave error responder with a Depth-entry outstanding-request FIFO.
// Optional error log (counter + first address) built when TLUL_ERR_RESP_LOG_EN is defined.

module tlul_err_resp_q
    import tlul_pkg::*;
#(
    parameter int unsigned      Depth   = 2,
    parameter logic [TL_DW-1:0] ErrData = 32'hFFFF_FFFF,
    parameter int unsigned      CntW    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  tl_h2d_t          tl_h_i,
    output tl_d2h_t          tl_h_o,
    input  logic             log_clr_i,
    output logic [CntW-1:0]  err_cnt_o,
    output logic [TL_AW-1:0] err_addr_o,
    output logic             err_addr_vld_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OccW = $clog2(Depth + 1);

    logic [TL_AIW-1:0] src_mem  [Depth];
    logic [TL_SZW-1:0] size_mem [Depth];
    tl_a_op_e          op_mem   [Depth];

    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [OccW-1:0] occ_q;
    logic            full, empty, push, pop;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (occ_q == OccW'(Depth));
    assign empty = (occ_q == '0);
    assign push  = tl_h_i.a_valid & ~full;
    assign pop   = ~empty & tl_h_i.d_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            if (push && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (!push && pop) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            src_mem[wptr_q]  <= tl_h_i.a_source;
            size_mem[wptr_q] <= tl_h_i.a_size;
            op_mem[wptr_q]   <= tl_h_i.a_opcode;
        end
    end

    // D fields are forced to zero while idle so the storage never leaks out.
    always_comb begin
        tl_h_o         = '0;
        tl_h_o.a_ready = ~full;
        if (!empty) begin
            tl_h_o.d_valid  = 1'b1;
            tl_h_o.d_opcode = (op_mem[rptr_q] == Get) ? AccessAckData : AccessAck;
            tl_h_o.d_size   = size_mem[rptr_q];
            tl_h_o.d_source = src_mem[rptr_q];
            tl_h_o.d_data   = ErrData;
            tl_h_o.d_error  = 1'b1;
        end
    end

`ifdef TLUL_ERR_RESP_LOG_EN
    logic [CntW-1:0]  cnt_q;
    logic [TL_AW-1:0] addr_q;
    logic             vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            addr_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if (log_clr_i) begin
                cnt_q <= '0;
            end else if (pop && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // A capture on the same edge as a clear takes priority over the clear.
            if (push && (!vld_q || log_clr_i)) begin
                addr_q <= tl_h_i.a_address;
                vld_q  <= 1'b1;
            end else if (log_clr_i) begin
                addr_q <= '0;
                vld_q  <= 1'b0;
            end
        end
    end

    assign err_cnt_o      = cnt_q;
    assign err_addr_o     = addr_q;
    assign err_addr_vld_o = vld_q;

    logic unused_a;
    assign unused_a = ^{tl_h_i.a_param, tl_h_i.a_mask, tl_h_i.a_data};
`else
    assign err_cnt_o      = '0;
    assign err_addr_o     = '0;
    assign err_addr_vld_o = 1'b0;

    logic unused_a;
    assign unused_a = ^{log_clr_i, tl_h_i.a_param, tl_h_i.a_mask, tl_h_i.a_data,
                        tl_h_i.a_address};
`endif

endmodule

// File: tb/tb_tlul_err_resp_q.sv
// Bench for tlul_err_resp_q: queue/log reference model checked every cycle plus directed pins.

module tb_tlul_err_resp_q;
    import tlul_pkg::*;

    localparam int Depth = 2;
`ifdef TLUL_ERR_RESP_LOG_EN
    localparam bit LogEn = 1'b1;
`else
    localparam bit LogEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    tl_h2d_t          h2d;
    tl_d2h_t          rsp, rsp_s;
    logic [15:0]      cnt;
    logic [1:0]       cnt_s;
    logic [TL_AW-1:0] addr, addr_s;
    logic             vld, vld_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tlul_err_resp_q #(.Depth(Depth), .ErrData(32'hFFFF_FFFF), .CntW(16)) dut (
        .clk_i(clk), .rst_i(rst), .tl_h_i(h2d), .tl_h_o(rsp), .log_clr_i(clr),
        .err_cnt_o(cnt), .err_addr_o(addr), .err_addr_vld_o(vld)
    );

    tlul_err_resp_q #(.Depth(Depth), .ErrData(32'hFFFF_FFFF), .CntW(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .tl_h_i(h2d), .tl_h_o(rsp_s), .log_clr_i(clr),
        .err_cnt_o(cnt_s), .err_addr_o(addr_s), .err_addr_vld_o(vld_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending requests as a queue, log as plain counters.
    typedef struct packed {
        logic [TL_AIW-1:0] src;
        logic [TL_SZW-1:0] size;
        tl_a_op_e          op;
    } ent_t;

    ent_t             q[$];
    int               raw_cnt = 0;
    logic [TL_AW-1:0] m_addr  = '0;
    bit               m_vld   = 1'b0;
    bit               started = 1'b0;
    bit               m_push, m_pop;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            raw_cnt = 0;
            m_addr  = '0;
            m_vld   = 1'b0;
        end else begin
            m_pop  = (q.size() > 0) && h2d.d_ready;
            m_push = h2d.a_valid && (q.size() < Depth);
            if (clr) raw_cnt = 0;
            else if (m_pop) raw_cnt++;
            if (m_push && (!m_vld || clr)) begin
                m_addr = h2d.a_address;
                m_vld  = 1'b1;
            end else if (clr) begin
                m_addr = '0;
                m_vld  = 1'b0;
            end
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back('{src: h2d.a_source, size: h2d.a_size, op: h2d.a_opcode});
        end
        started = 1'b1;
    end

    task automatic cmp_dut(input string tag, input tl_d2h_t o, input logic [15:0] c,
                           input logic [TL_AW-1:0] a, input logic v, input int maxc);
        int exp_cnt;
        exp_cnt = (raw_cnt > maxc) ? maxc : raw_cnt;
        chk({tag, "_a_ready"}, o.a_ready, q.size() < Depth);
        chk({tag, "_d_valid"}, o.d_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk({tag, "_d_source"}, o.d_source, q[0].src);
            chk({tag, "_d_size"},   o.d_size,   q[0].size);
            chk({tag, "_d_opcode"}, o.d_opcode,
                (q[0].op == Get) ? AccessAckData : AccessAck);
            chk({tag, "_d_data"},   o.d_data,   32'hFFFF_FFFF);
            chk({tag, "_d_error"},  o.d_error,  1'b1);
            chk({tag, "_d_param"},  o.d_param,  3'h0);
            chk({tag, "_d_sink"},   o.d_sink,   1'b0);
        end
        chk({tag, "_err_cnt"},  c, LogEn ? exp_cnt : 0);
        chk({tag, "_err_addr"}, a, LogEn ? m_addr : '0);
        chk({tag, "_err_vld"},  v, LogEn ? m_vld : 1'b0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_dut("mdl", rsp, cnt, addr, vld, 65535);
            cmp_dut("mdl_sat", rsp_s, {14'h0, cnt_s}, addr_s, vld_s, 3);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input tl_a_op_e op, input logic [7:0] src,
                           input logic [1:0] size, input logic [31:0] a);
        h2d.a_valid   = v;
        h2d.a_opcode  = op;
        h2d.a_source  = src;
        h2d.a_size    = size;
        h2d.a_address = a;
        h2d.a_data    = 32'hDEAD_BEEF;
        h2d.a_mask    = 4'hF;
    endtask

    initial begin
        h2d = '0;
        rst = 1'b1;
        clr = 1'b0;
        cyc();
        @(negedge clk);
        chk("rst_a_ready", rsp.a_ready, 1'b1);
        chk("rst_d_valid", rsp.d_valid, 1'b0);
        chk("rst_d_data",  rsp.d_data,  32'h0);
        chk("rst_d_error", rsp.d_error, 1'b0);
        chk("rst_err_cnt", cnt, 16'h0);
        chk("rst_err_vld", vld, 1'b0);
        chk("rst_err_addr", addr, 32'h0);
        cyc();
        rst = 1'b0;

        // Single Get
        h2d.d_ready = 1'b1;
        drive_a(1'b1, Get, 8'd3, 2'd2, 32'h1000_0040);
        cyc();
        drive_a(1'b0, Get, 8'd0, 2'd0, 32'h0);
        @(negedge clk);
        chk("get_d_valid",  rsp.d_valid,  1'b1);
        chk("get_d_opcode", rsp.d_opcode, AccessAckData);
        chk("get_d_source", rsp.d_source, 8'd3);
        chk("get_d_size",   rsp.d_size,   2'd2);
        chk("get_d_data",   rsp.d_data,   32'hFFFF_FFFF);
        chk("get_d_error",  rsp.d_error,  1'b1);
        cyc();
        @(negedge clk);
        chk("get_err_cnt",  cnt,  LogEn ? 16'd1 : 16'd0);
        chk("get_err_addr", addr, LogEn ? 32'h1000_0040 : 32'h0);
        chk("get_err_vld",  vld,  LogEn);

        // Fill and drain
        cyc();
        h2d.d_ready = 1'b0;
        drive_a(1'b1, PutFullData, 8'd1, 2'd2, 32'h1000_0100);
        cyc();
        drive_a(1'b1, PutFullData, 8'd2, 2'd2, 32'h1000_0104);
        cyc();
        drive_a(1'b1, PutFullData, 8'd3, 2'd2, 32'h1000_0108);
        @(negedge clk);
        chk("fill_a_ready", rsp.a_ready, 1'b0);
        chk("fill_head",    rsp.d_source, 8'd1);
        cyc();
        @(negedge clk);
        chk("fill_stall", rsp.a_ready, 1'b0);
        h2d.d_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("drain_src2",    rsp.d_source, 8'd2);
        chk("drain_a_ready", rsp.a_ready,  1'b1);
        cyc();
        drive_a(1'b0, Get, 8'd0, 2'd0, 32'h0);
        @(negedge clk);
        chk("drain_src3",   rsp.d_source, 8'd3);
        chk("drain_opcode", rsp.d_opcode, AccessAck);
        cyc();
        @(negedge clk);
        chk("drain_empty", rsp.d_valid, 1'b0);
        chk("drain_cnt",   cnt, LogEn ? 16'd4 : 16'd0);

        // Back-to-back after a clear
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, Get, 8'(i + 8), 2'd1, 32'h2000_0000 + 32'(i * 4));
            @(negedge clk);
            chk("b2b_a_ready", rsp.a_ready, 1'b1);
            if (i > 0) begin
                chk("b2b_d_valid", rsp.d_valid, 1'b1);
                chk("b2b_order",   rsp.d_source, 8'(i + 7));
            end
            cyc();
        end
        drive_a(1'b0, Get, 8'd0, 2'd0, 32'h0);
        @(negedge clk);
        chk("b2b_last", rsp.d_source, 8'd15);
        cyc();
        @(negedge clk);
        chk("b2b_done",   rsp.d_valid, 1'b0);
        chk("b2b_cnt",    cnt,   LogEn ? 16'd8 : 16'd0);
        chk("b2b_cnt_sat", cnt_s, LogEn ? 2'd3 : 2'd0);
        chk("b2b_addr",   addr,  LogEn ? 32'h2000_0000 : 32'h0);

        // Clear coinciding with a D handshake
        cyc();
        drive_a(1'b1, Get, 8'd5, 2'd0, 32'h3000_0000);
        cyc();
        drive_a(1'b0, Get, 8'd0, 2'd0, 32'h0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_d_cnt",     cnt,   16'd0);
        chk("clr_d_cnt_sat", cnt_s, 2'd0);
        chk("clr_d_vld",     vld,   1'b0);

        // Clear coinciding with an A handshake: capture wins
        cyc();
        drive_a(1'b1, Get, 8'd6, 2'd0, 32'h4000_0000);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        drive_a(1'b0, Get, 8'd0, 2'd0, 32'h0);
        @(negedge clk);
        chk("clr_a_vld",  vld,  LogEn);
        chk("clr_a_addr", addr, LogEn ? 32'h4000_0000 : 32'h0);
        cyc();

        // Reset with the queue full
        h2d.d_ready = 1'b0;
        drive_a(1'b1, PutFullData, 8'd1, 2'd2, 32'h5000_0000);
        cyc();
        drive_a(1'b1, PutFullData, 8'd2, 2'd2, 32'h5000_0004);
        cyc();
        drive_a(1'b0, Get, 8'd0, 2'd0, 32'h0);
        @(negedge clk);
        chk("full_a_ready", rsp.a_ready, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rstq_d_valid", rsp.d_valid, 1'b0);
        chk("rstq_a_ready", rsp.a_ready, 1'b1);
        chk("rstq_cnt",     cnt,  16'd0);
        chk("rstq_vld",     vld,  1'b0);
        chk("rstq_addr",    addr, 32'h0);
        h2d.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("rstq_no_stale", rsp.d_valid, 1'b0);
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
